audio_in_capture: RTL and testbench

Receive-side companion to the tone/waveform playback path. Drains stereo samples from the Audio_Controller input FIFO (`audio_in_available` / `read_audio_in` / `*_channel_audio_in`) and truncates each channel to `SAMPLE_W` bits. Re-presents each pair on a valid/ready stream for synth-side consumers such as a recorder or effects. Optionally maintains a decaying peak-level meter and a sticky clip flag for LED/HEX display.

---
 rtl/audio_in_pkg.sv | 23 ++
 rtl/audio_peak_meter.sv | 76 +++++++
 rtl/audio_in_capture.sv | 96 +++++++++
 tb/tb_audio_in_capture.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_in_pkg.sv
// Shared types and defaults for the audio input capture path.
package audio_in_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      WAIT = 2'd2
   } cap_state_t;

   localparam int SAMPLE_W_DEF  = 16;
   localparam int LEVEL_W_DEF   = 7;
   localparam int DECAY_DIV_DEF = 50000;

   // Two's-complement extremes of a w-bit sample, as raw bit patterns.
   function automatic logic [31:0] sample_max(input int w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   function automatic logic [31:0] sample_min(input int w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/audio_peak_meter.sv
// Decaying peak-level meter of the mono magnitude plus a sticky clip flag,
// both updated on the capture edge of the input stream.
module audio_peak_meter
   import audio_in_pkg::*;
#(
   parameter int SAMPLE_W  = SAMPLE_W_DEF,
   parameter int LEVEL_W   = LEVEL_W_DEF,
   parameter int DECAY_DIV = DECAY_DIV_DEF
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic                capture,
   input  logic                clear_clip,
   input  logic [SAMPLE_W-1:0] cap_left,
   input  logic [SAMPLE_W-1:0] cap_right,
   output logic [LEVEL_W-1:0]  peak_level,
   output logic                clip
);

   localparam int CNT_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DECAY_DIV - 1);
   localparam logic [SAMPLE_W-1:0] S_MAX    = SAMPLE_W'(sample_max(SAMPLE_W));
   localparam logic [SAMPLE_W-1:0] S_MIN    = SAMPLE_W'(sample_min(SAMPLE_W));

   logic signed [SAMPLE_W:0] sum;
   logic signed [SAMPLE_W:0] mono;
   logic [SAMPLE_W-1:0]      mag;
   logic [LEVEL_W-1:0]       cand;
   logic                     hit_rail;
   logic [CNT_W-1:0]         decay_cnt;
   logic                     decay_tick;

   // The halved sum always fits SAMPLE_W signed bits; only the most negative
   // value has no positive twin and is pinned to full scale.
   always_comb begin
      sum  = {cap_left[SAMPLE_W-1], cap_left} + {cap_right[SAMPLE_W-1], cap_right};
      mono = sum >>> 1;
      mag  = mono[SAMPLE_W-1:0];
      if (mono[SAMPLE_W]) begin
         if (mono[SAMPLE_W-1:0] == S_MIN)
            mag = S_MAX;
         else
            mag = ~mono[SAMPLE_W-1:0] + 1'b1;
      end
      cand = LEVEL_W'(mag >> (SAMPLE_W - 1 - LEVEL_W));
   end

   assign hit_rail = (cap_left == S_MAX) || (cap_left == S_MIN) ||
                     (cap_right == S_MAX) || (cap_right == S_MIN);

   assign decay_tick = (decay_cnt == CNT_LAST);

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         decay_cnt  <= '0;
         peak_level <= '0;
         clip       <= 1'b0;
      end else begin
         decay_cnt <= decay_tick ? '0 : decay_cnt + 1'b1;

         // A capture swallows any decay step landing on the same edge.
         if (capture) begin
            if (cand > peak_level)
               peak_level <= cand;
         end else if (decay_tick && (peak_level != '0)) begin
            peak_level <= peak_level - 1'b1;
         end

         if (capture && hit_rail)
            clip <= 1'b1;
         else if (clear_clip)
            clip <= 1'b0;
      end
   end

endmodule

// File: rtl/audio_in_capture.sv
// Drains stereo words from the Audio_Controller input FIFO onto a valid/ready
// stream. Peak meter and clip flag are built only with AUDIO_IN_PEAK_EN.
//
// state | meaning
// IDLE  | pop the FIFO head whenever it is available and capture it
// HOLD  | pair presented on the stream, waiting for sample_ready
// WAIT  | one settle cycle so the FIFO flags reflect the last pop
module audio_in_capture
   import audio_in_pkg::*;
#(
   parameter int SAMPLE_W  = SAMPLE_W_DEF,
   parameter int LEVEL_W   = LEVEL_W_DEF,
   parameter int DECAY_DIV = DECAY_DIV_DEF
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic                audio_in_available,
   input  logic [31:0]         left_channel_audio_in,
   input  logic [31:0]         right_channel_audio_in,
   output logic                read_audio_in,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic [SAMPLE_W-1:0] sample_left,
   output logic [SAMPLE_W-1:0] sample_right,
   output logic [LEVEL_W-1:0]  peak_level,
   output logic                clip,
   input  logic                clear_clip
);

   cap_state_t          state;
   logic                pop_ok;
   logic [SAMPLE_W-1:0] head_left;
   logic [SAMPLE_W-1:0] head_right;

   assign head_left  = SAMPLE_W'(left_channel_audio_in  >> (32 - SAMPLE_W));
   assign head_right = SAMPLE_W'(right_channel_audio_in >> (32 - SAMPLE_W));

   assign pop_ok        = (state == IDLE) && audio_in_available;
   assign read_audio_in = pop_ok && resetn;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         sample_valid <= 1'b0;
         sample_left  <= '0;
         sample_right <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (audio_in_available) begin
                  sample_left  <= head_left;
                  sample_right <= head_right;
                  sample_valid <= 1'b1;
                  state        <= HOLD;
               end
            end
            HOLD: begin
               if (sample_ready) begin
                  sample_valid <= 1'b0;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               state <= IDLE;
            end
            default: begin
               sample_valid <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

`ifdef AUDIO_IN_PEAK_EN
   audio_peak_meter #(
      .SAMPLE_W  (SAMPLE_W),
      .LEVEL_W   (LEVEL_W),
      .DECAY_DIV (DECAY_DIV)
   ) u_peak_meter (
      .CLOCK_50   (CLOCK_50),
      .resetn     (resetn),
      .capture    (pop_ok),
      .clear_clip (clear_clip),
      .cap_left   (head_left),
      .cap_right  (head_right),
      .peak_level (peak_level),
      .clip       (clip)
   );
`else
   logic unused_clear_clip;
   assign unused_clear_clip = clear_clip;
   assign peak_level        = '0;
   assign clip              = 1'b0;
`endif

endmodule

// File: tb/tb_audio_in_capture.sv
// Scoreboard bench for audio_in_capture: a FIFO model feeds the DUT and the
// expected truncated pairs are compared as the stream hands them over.
module tb_audio_in_capture;

   localparam int SW  = 16;
   localparam int LW  = 7;
   localparam int DIV = 20;

`ifdef AUDIO_IN_PEAK_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   logic          CLOCK_50 = 1'b0;
   logic          resetn = 1'b0;
   logic          audio_in_available = 1'b0;
   logic [31:0]   left_channel_audio_in = '0;
   logic [31:0]   right_channel_audio_in = '0;
   logic          read_audio_in;
   logic          sample_valid;
   logic          sample_ready = 1'b0;
   logic [SW-1:0] sample_left;
   logic [SW-1:0] sample_right;
   logic [LW-1:0] peak_level;
   logic          clip;
   logic          clear_clip = 1'b0;

   always #10 CLOCK_50 = ~CLOCK_50;

   audio_in_capture #(
      .SAMPLE_W  (SW),
      .LEVEL_W   (LW),
      .DECAY_DIV (DIV)
   ) dut (
      .CLOCK_50               (CLOCK_50),
      .resetn                 (resetn),
      .audio_in_available     (audio_in_available),
      .left_channel_audio_in  (left_channel_audio_in),
      .right_channel_audio_in (right_channel_audio_in),
      .read_audio_in          (read_audio_in),
      .sample_valid           (sample_valid),
      .sample_ready           (sample_ready),
      .sample_left            (sample_left),
      .sample_right           (sample_right),
      .peak_level             (peak_level),
      .clip                   (clip),
      .clear_clip             (clear_clip)
   );

   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [31:0] fifo_l[$];
   logic [31:0] fifo_r[$];
   logic [31:0] sb[$];
   int          cyc = 0;
   int          pop_cnt = 0;
   int          last_pop = -100;
   int          last_acc = -100;
   logic        prev_rd = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive();
      if (fifo_l.size() != 0) begin
         audio_in_available     = 1'b1;
         left_channel_audio_in  = fifo_l[0];
         right_channel_audio_in = fifo_r[0];
      end else begin
         audio_in_available     = 1'b0;
         left_channel_audio_in  = '0;
         right_channel_audio_in = '0;
      end
   endtask

   task automatic push(input logic [31:0] l, input logic [31:0] r);
      fifo_l.push_back(l);
      fifo_r.push_back(r);
      sb.push_back({l[31:16], r[31:16]});
      drive();
   endtask

   // One clock: observe at the falling edge, update the FIFO model after the rise.
   task automatic cycle();
      logic        pop;
      logic        acc;
      logic [31:0] e;
      @(negedge CLOCK_50);
      pop = read_audio_in;
      acc = sample_valid && sample_ready;
      chk("rd_back_to_back", 32'(pop & prev_rd), 32'd0);
      chk("rd_while_valid", 32'(pop & sample_valid), 32'd0);
      if (pop) begin
         pop_cnt++;
         last_pop = cyc;
      end
      if (acc) begin
         last_acc = cyc;
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("left", 32'(sample_left), 32'(e[31:16]));
            chk("right", 32'(sample_right), 32'(e[15:0]));
         end
      end
      prev_rd = pop;
      @(posedge CLOCK_50);
      cyc++;
      #1;
      if (pop && fifo_l.size() != 0) begin
         void'(fifo_l.pop_front());
         void'(fifo_r.pop_front());
      end
      drive();
   endtask

   task automatic wait_pop(input int budget);
      int start;
      start = pop_cnt;
      for (int i = 0; i < budget && pop_cnt == start; i++) cycle();
      chk("pop_seen", 32'(pop_cnt - start), 32'd1);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (sb.size() != 0 || fifo_l.size() != 0); i++) cycle();
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p;
      int pc;

      // Reset with a word already waiting: no pop may happen while held.
      resetn = 1'b0;
      push(32'h12340000, 32'hFFFF0000);
      repeat (2) @(posedge CLOCK_50);
      #1;
      chk("rst_read", 32'(read_audio_in), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_left", 32'(sample_left), 32'd0);
      chk("rst_right", 32'(sample_right), 32'd0);
      chk("rst_peak", 32'(peak_level), 32'd0);
      chk("rst_clip", 32'(clip), 32'd0);
      resetn = 1'b1;

      // First capture, held with sample_ready low.
      wait_pop(10);
      chk("pop_count", 32'(pop_cnt), 32'd1);
      chk("cap_valid", 32'(sample_valid), 32'd1);
      chk("cap_left", 32'(sample_left), 32'h1234);
      chk("cap_right", 32'(sample_right), 32'hFFFF);
      chk("cap_peak", 32'(peak_level), PEAK_EN ? 32'h09 : 32'd0);
      chk("cap_clip", 32'(clip), 32'd0);

      // Backpressure: data stable, no further pops.
      push(32'h00050000, 32'hFFFB0000);
      push(32'h7FFE0001, 32'h8001FFFF);
      pc = pop_cnt;
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("hold_left", 32'(sample_left), 32'h1234);
      end
      chk("hold_pops", 32'(pop_cnt - pc), 32'd0);
      sample_ready = 1'b1;
      wait_pop(10);
      chk("pop_after_accept", 32'(last_pop - last_acc), 32'd2);

      // Streaming at full rate: one pop every third cycle.
      for (int i = 0; i < 6; i++) push($urandom, $urandom);
      for (int k = 0; k < 5; k++) begin
         p = last_pop;
         wait_pop(10);
         chk("pop_gap", 32'(last_pop - p), 32'd3);
      end
      drain(60);

      // Full-scale positive: clip, peak at full scale, then three decay steps.
      push(32'h7FFF0000, 32'h7FFF0000);
      wait_pop(10);
      chk("fs_clip", 32'(clip), PEAK_EN ? 32'd1 : 32'd0);
      chk("fs_peak", 32'(peak_level), PEAK_EN ? 32'h7F : 32'd0);
      for (int i = 0; i < 3 * DIV; i++) cycle();
      chk("decay_peak", 32'(peak_level), PEAK_EN ? 32'h7C : 32'd0);
      clear_clip = 1'b1;
      cycle();
      clear_clip = 1'b0;
      chk("clear_clip", 32'(clip), 32'd0);

      // Most-negative pair: magnitude saturates to full scale, min also clips.
      push(32'h80000000, 32'h80000000);
      wait_pop(10);
      chk("neg_peak", 32'(peak_level), PEAK_EN ? 32'h7F : 32'd0);
      chk("neg_clip", 32'(clip), PEAK_EN ? 32'd1 : 32'd0);
      drain(20);

      // Asynchronous reset while holding a pair.
      sample_ready = 1'b0;
      repeat (2) cycle();
      push(32'h0ABC0000, 32'hF5430000);
      push(32'h00010000, 32'h00020000);
      wait_pop(10);
      chk("pre_rst_valid", 32'(sample_valid), 32'd1);
      #4;
      resetn = 1'b0;
      #1;
      chk("arst_valid", 32'(sample_valid), 32'd0);
      chk("arst_left", 32'(sample_left), 32'd0);
      chk("arst_peak", 32'(peak_level), 32'd0);
      chk("arst_clip", 32'(clip), 32'd0);
      chk("arst_read", 32'(read_audio_in), 32'd0);
      void'(sb.pop_front());
      for (int i = 0; i < 3; i++) begin
         @(negedge CLOCK_50);
         chk("arst_read_hold", 32'(read_audio_in), 32'd0);
      end
      @(posedge CLOCK_50);
      #1;
      resetn = 1'b1;
      prev_rd = 1'b0;
      sample_ready = 1'b1;
      drain(20);
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
